// File: rtl/posit_operand_sequencer.sv
// posit_operand_sequencer
//   Front-end controller for two-operand posit units. It accepts an (A,B)
//   operand pair over valid/ready and decodes A and then B on one shared
//   posit_decoder. It holds both decoded results until the consumer
//   accepts them.
//
//   Optional feature macro: DEC_TIMEOUT_EN. When it is defined, a WAIT
//   state that sees no dec_done within TIMEOUT_CYCLES cycles aborts to
//   HOLD with out_err=1.
//
// Ports
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake (in_ready high only in IDLE)
//   in_a, in_b            32-bit posit operands
//   out_valid/out_ready   decoded pair handshake (out_valid held in HOLD)
//   out_err               decode aborted by timeout
//   a_*/b_*               sign, zero, NaR, regime k (signed), exponent, mantissa
//   dec_posit, dec_start  to the decoder
//   dec_*                 from the decoder (done, flags, fields)
module posit_operand_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_err,
  output logic        a_sign,
  output logic        a_zero,
  output logic        a_nar,
  output logic [5:0]  a_k,
  output logic [2:0]  a_exp,
  output logic [31:0] a_mant,
  output logic        b_sign,
  output logic        b_zero,
  output logic        b_nar,
  output logic [5:0]  b_k,
  output logic [2:0]  b_exp,
  output logic [31:0] b_mant,
  output logic [31:0] dec_posit,
  output logic        dec_start,
  input  logic        dec_sign,
  input  logic        dec_done,
  input  logic        dec_zero,
  input  logic        dec_nar,
  input  logic [5:0]  dec_k,
  input  logic [2:0]  dec_exp,
  input  logic [31:0] dec_mant
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH_A, S_WAIT_A, S_GAP, S_LAUNCH_B, S_WAIT_B, S_HOLD
  } state_t;

  state_t      state, state_nx;
  logic [31:0] op_a, op_b;
  logic [43:0] res_a, res_b;
  logic [43:0] dec_bus;
  logic        timeout;

  assign dec_bus = {dec_sign, dec_zero, dec_nar, dec_k, dec_exp, dec_mant};
  assign {a_sign, a_zero, a_nar, a_k, a_exp, a_mant} = res_a;
  assign {b_sign, b_zero, b_nar, b_k, b_exp, b_mant} = res_b;

`ifdef DEC_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic          in_wait;

  assign in_wait = (state == S_WAIT_A) || (state == S_WAIT_B);
  // The last counted WAIT cycle without done is the abort cycle.
  assign timeout = !dec_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign out_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == S_LAUNCH_A) || (state == S_LAUNCH_B)) wait_cnt <= '0;
      else if (in_wait)                                    wait_cnt <= wait_cnt + CW'(1);
      if (in_wait && timeout)                  err_q <= 1'b1;
      else if ((state == S_HOLD) && out_ready) err_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dec_start = 1'b0;
    dec_posit = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_LAUNCH_A;
      end
      S_LAUNCH_A: begin
        dec_start = 1'b1;
        dec_posit = op_a;
        state_nx  = S_WAIT_A;
      end
      S_WAIT_A: begin
        dec_posit = op_a;
        if (dec_done)     state_nx = S_GAP;
        else if (timeout) state_nx = S_HOLD;
      end
      // The decoder's done is still high from A here; the gap keeps that
      // stale done away from the B launch.
      S_GAP: state_nx = S_LAUNCH_B;
      S_LAUNCH_B: begin
        dec_start = 1'b1;
        dec_posit = op_b;
        state_nx  = S_WAIT_B;
      end
      S_WAIT_B: begin
        dec_posit = op_b;
        if (dec_done || timeout) state_nx = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res_a <= '0;
      res_b <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_a <= in_a;
          op_b <= in_b;
        end
        S_WAIT_A: begin
          if (dec_done) res_a <= dec_bus;
          else if (timeout) begin
            res_a <= '0;
            res_b <= '0;
          end
        end
        S_WAIT_B: begin
          if (dec_done)     res_b <= dec_bus;
          else if (timeout) res_b <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
